frame_builder: RTL

Upstream byte source for the serializing FIFO in the transmit framing chain. Accepts a PSDU from the host through a valid/ready stream and emits the full frame byte by byte: PHR length byte, PSDU, then the 2-byte FCS (CRC-16). The output drives the FIFO's 8-bit input and valid pins, which have no backpressure. The block therefore paces its output with an internal credit model of the FIFO's occupancy and drain rate, so no byte is ever offered to a full FIFO.

---
 rtl/frame_builder.sv | 109 ++++++++++
 1 files changed

// File: rtl/frame_builder.sv
// frame_builder: emits PHR, PSDU and CRC-16/KERMIT FCS bytes into a serializing FIFO, paced by a credit model of its occupancy
module frame_builder #(
  parameter int FIFO_DEPTH = 8,
  parameter int SHR_BITS   = 80,
  parameter int MAX_PSDU   = 125,
  parameter int IFS_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_len,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] frame_byte,
  output logic       frame_byte_valid,
  output logic       tx_busy,
  output logic       len_err,
  output logic       underrun
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(SHR_BITS + 10);
  localparam int GW = $clog2(IFS_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, PHR, PSDU, FCS_LO, FCS_HI, DRAIN, GAP} state_t;
  state_t state;
  logic [CW-1:0] credits, credits_nxt;
  logic [TW-1:0] tmr;
  logic [GW-1:0] gap_cnt;
  logic [7:0] len, rem, out_byte;
  logic [15:0] crc;
  logic tmr_on, ret, emit, accept, have_credit, full_nxt;
  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 16'h8408 : r >> 1;
    return r;
  endfunction
  assign have_credit = credits != '0;
  assign in_ready = state == PSDU && have_credit;
  assign accept = in_ready && in_valid;
  assign ret = tmr_on && tmr == '0;
  assign emit = accept || (have_credit && (state == PHR || state == FCS_LO || state == FCS_HI));
  assign full_nxt = credits_nxt == CW'(FIFO_DEPTH);
  always_comb begin
    credits_nxt = (ret && !emit && credits != CW'(FIFO_DEPTH)) ? credits + CW'(1) :
                  (emit && !ret) ? credits - CW'(1) : credits;
    out_byte = state == PHR ? len + 8'd2 : state == PSDU ? in_data :
               state == FCS_LO ? crc[7:0] : crc[15:8];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      credits <= CW'(FIFO_DEPTH);
      tmr_on <= 1'b0;
      tmr <= '0;
      gap_cnt <= '0;
      len <= '0;
      rem <= '0;
      crc <= '0;
      frame_byte <= '0;
      frame_byte_valid <= 1'b0;
      tx_busy <= 1'b0;
      len_err <= 1'b0;
      underrun <= 1'b0;
    end else begin
      credits <= credits_nxt;
      frame_byte_valid <= emit;
      len_err <= 1'b0;
      underrun <= state == PSDU && ret && full_nxt;
      if (emit) frame_byte <= out_byte;
      // the FIFO only prepends an SHR at frame start; after an underrun it resumes straight into data
      if (emit && !tmr_on) begin
        tmr_on <= 1'b1;
        tmr <= state == PHR ? TW'(SHR_BITS + 9) : TW'(9);
      end else if (ret) begin
        tmr_on <= !full_nxt;
        tmr <= TW'(7);
      end else if (tmr_on) tmr <= tmr - TW'(1);
      case (state)
        IDLE: if (tx_start) begin
          if (tx_len != '0 && tx_len <= 8'(MAX_PSDU)) begin
            len <= tx_len;
            rem <= tx_len;
            crc <= '0;
            state <= PHR;
            tx_busy <= 1'b1;
          end else len_err <= 1'b1;
        end
        PHR: if (have_credit) state <= PSDU;
        PSDU: if (accept) begin
          crc <= crc_fold(crc, in_data);
          rem <= rem - 8'd1;
          if (rem == 8'd1) state <= FCS_LO;
        end
        FCS_LO: if (have_credit) state <= FCS_HI;
        FCS_HI: if (have_credit) state <= DRAIN;
        DRAIN: if (credits == CW'(FIFO_DEPTH)) begin
          state <= GAP;
          gap_cnt <= '0;
        end
        GAP: if (gap_cnt == GW'(IFS_CYCLES - 1)) begin
          state <= IDLE;
          tx_busy <= 1'b0;
        end else gap_cnt <= gap_cnt + GW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
